// File: rtl/gate_selftest_seq.sv
// Self-test sequencer for the two-input gate block: sweeps a/b, compares the six gate results to a golden table.
// Define GATE_SELFTEST_FAULT_INJECT_EN to add inject_mask[5:0], XORed onto the received gate values before compare.
module gate_selftest_seq #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned NUM_PASSES    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef GATE_SELFTEST_FAULT_INJECT_EN
   input  logic [5:0] inject_mask,
`endif
   output logic       a_out,
   output logic       b_out,
   input  logic       and_in,
   input  logic       or_in,
   input  logic       not_a_in,
   input  logic       xor_in,
   input  logic       xnor_in,
   input  logic       nand_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [5:0] fail_vec
);

   // state    | meaning
   // S_IDLE   | waiting for start; results from the last run are held
   // S_SETTLE | vector idx_q driven, settle_q counts down to zero
   // S_SAMPLE | one cycle: compare gate results, accumulate errors, advance
   // S_DONE   | one-cycle done pulse, pass resolved, operands parked at 0
   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] settle_q, settle_d;
   logic [7:0] pass_cnt_q, pass_cnt_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [7:0] err_q, err_d;
   logic [5:0] fail_q, fail_d;

   logic [5:0] rx_vals;
   logic [5:0] golden;
   logic [5:0] mism;
   logic [7:0] err_sampled;
   logic [1:0] idx_next;
   logic       ga;
   logic       gb;

   // Golden is derived from idx_q, which always matches the registered a_out/b_out during a run.
   assign ga = idx_q[1];
   assign gb = idx_q[0];
   assign golden = {~(ga & gb), ~(ga ^ gb), ga ^ gb, ~ga, ga | gb, ga & gb};

`ifdef GATE_SELFTEST_FAULT_INJECT_EN
   assign rx_vals = {nand_in, xnor_in, xor_in, not_a_in, or_in, and_in} ^ inject_mask;
`else
   assign rx_vals = {nand_in, xnor_in, xor_in, not_a_in, or_in, and_in};
`endif

   assign mism        = rx_vals ^ golden;
   assign err_sampled = ((|mism) && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
   assign idx_next    = idx_q + 2'd1;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      settle_d   = settle_q;
      pass_cnt_d = pass_cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      err_d      = err_q;
      fail_d     = fail_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_SETTLE;
               idx_d      = 2'd0;
               settle_d   = SETTLE_LOAD;
               pass_cnt_d = 8'd0;
               a_d        = 1'b0;
               b_d        = 1'b0;
               busy_d     = 1'b1;
               pass_d     = 1'b0;
               err_d      = 8'd0;
               fail_d     = 6'd0;
            end
         end
         S_SETTLE: begin
            if (settle_q == 4'd0) begin
               state_d = S_SAMPLE;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            fail_d = fail_q | mism;
            err_d  = err_sampled;
            if ((idx_q == 2'd3) && (pass_cnt_q == LAST_PASS)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               pass_d  = (err_sampled == 8'd0);
            end else begin
               state_d  = S_SETTLE;
               idx_d    = idx_next;
               a_d      = idx_next[1];
               b_d      = idx_next[0];
               settle_d = SETTLE_LOAD;
               if (idx_q == 2'd3) begin
                  pass_cnt_d = pass_cnt_q + 8'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= 2'd0;
         settle_q   <= 4'd0;
         pass_cnt_q <= 8'd0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= 8'd0;
         fail_q     <= 6'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         settle_q   <= settle_d;
         pass_cnt_q <= pass_cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         fail_q     <= fail_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Directed bench for gate_selftest_seq: three instances (defaults, 3 passes, 70 passes/1 settle) with a behavioural gate block.
module tb_gate_selftest_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   function automatic logic [5:0] gate_vals(input logic a, input logic b);
      return {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
   endfunction

   // Instance 0: default parameters
   logic       start0 = 1'b0;
   logic       a0, b0, busy0, done0, pass0;
   logic [7:0] err0;
   logic [5:0] fv0;
   logic [5:0] flt0 = 6'd0;
   logic       and0_stuck = 1'b0;
   logic [5:0] g0;
   assign g0 = (gate_vals(a0, b0) ^ flt0) & {5'b11111, ~and0_stuck};

   // Instance 3: NUM_PASSES=3
   logic       start3 = 1'b0;
   logic       a3, b3, busy3, done3, pass3;
   logic [7:0] err3;
   logic [5:0] fv3;
   logic [5:0] flt3 = 6'd0;
   logic [5:0] g3;
   assign g3 = gate_vals(a3, b3) ^ flt3;

   // Instance 70: NUM_PASSES=70, SETTLE_CYCLES=1
   logic       start70 = 1'b0;
   logic       a70, b70, busy70, done70, pass70;
   logic [7:0] err70;
   logic [5:0] fv70;
   logic [5:0] flt70 = 6'd0;
   logic [5:0] g70;
   assign g70 = gate_vals(a70, b70) ^ flt70;

`ifdef GATE_SELFTEST_FAULT_INJECT_EN
   logic [5:0] inj0 = 6'd0;
   logic [5:0] inj_zero = 6'd0;
`endif

   gate_selftest_seq u_dut0 (
      .clk(clk), .rst(rst), .start(start0),
`ifdef GATE_SELFTEST_FAULT_INJECT_EN
      .inject_mask(inj0),
`endif
      .a_out(a0), .b_out(b0),
      .and_in(g0[0]), .or_in(g0[1]), .not_a_in(g0[2]),
      .xor_in(g0[3]), .xnor_in(g0[4]), .nand_in(g0[5]),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
   );

   gate_selftest_seq #(.SETTLE_CYCLES(2), .NUM_PASSES(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3),
`ifdef GATE_SELFTEST_FAULT_INJECT_EN
      .inject_mask(inj_zero),
`endif
      .a_out(a3), .b_out(b3),
      .and_in(g3[0]), .or_in(g3[1]), .not_a_in(g3[2]),
      .xor_in(g3[3]), .xnor_in(g3[4]), .nand_in(g3[5]),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3)
   );

   gate_selftest_seq #(.SETTLE_CYCLES(1), .NUM_PASSES(70)) u_dut70 (
      .clk(clk), .rst(rst), .start(start70),
`ifdef GATE_SELFTEST_FAULT_INJECT_EN
      .inject_mask(inj_zero),
`endif
      .a_out(a70), .b_out(b70),
      .and_in(g70[0]), .or_in(g70[1]), .not_a_in(g70[2]),
      .xor_in(g70[3]), .xnor_in(g70[4]), .nand_in(g70[5]),
      .busy(busy70), .done(done70), .pass(pass70), .err_count(err70), .fail_vec(fv70)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles until the selected instance raises done; an expired bound returns the limit.
   task automatic wait_done(input int sel, input int limit, output int n);
      logic d;
      n = 0;
      d = (sel == 0) ? done0 : (sel == 3) ? done3 : done70;
      while (!d && n < limit) begin
         tick();
         n++;
         d = (sel == 0) ? done0 : (sel == 3) ? done3 : done70;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0, fv0} !== 19'd0) begin
         errors++;
         $display("FAIL reset_dut0 got a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b want all 0",
                  a0, b0, busy0, done0, pass0, err0, fv0);
      end
      checks++;
      if ({a3, b3, busy3, done3, pass3, err3, fv3, a70, b70, busy70, done70, pass70, err70, fv70} !== 38'd0) begin
         errors++;
         $display("FAIL reset_dut3_70 got busy3=%b err3=%0d busy70=%b err70=%0d want all 0", busy3, err3, busy70, err70);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_good_sweep();
      logic [1:0] exp_v;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         exp_v = 2'(k / 3);
         checks++;
         if ({a0, b0} !== exp_v || busy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_cycle%0d got ab=%b%b busy=%b done=%b want ab=%b busy=1 done=0",
                     k, a0, b0, busy0, done0, exp_v);
         end
         tick();
      end
      checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b0 || {a0, b0} !== 2'b00) begin
         errors++;
         $display("FAIL sweep_done_cycle12 got done=%b busy=%b ab=%b%b want done=1 busy=0 ab=00", done0, busy0, a0, b0);
      end
      checks++;
      if (pass0 !== 1'b1 || err0 !== 8'd0 || fv0 !== 6'b000000) begin
         errors++;
         $display("FAIL sweep_result got pass=%b err=%0d fv=%b want pass=1 err=0 fv=000000", pass0, err0, fv0);
      end
      tick();
      checks++;
      if (done0 !== 1'b0 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL sweep_done_pulse got done=%b pass=%b want done=0 pass=1", done0, pass0);
      end
   endtask

   task automatic test_stuck_and();
      int n;
      and0_stuck = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 100, n);
      checks++;
      if (n !== 12) begin
         errors++;
         $display("FAIL stuck_and_latency got %0d cycles want 12", n);
      end
      checks++;
      if (err0 !== 8'd1 || fv0 !== 6'b000001 || pass0 !== 1'b0) begin
         errors++;
         $display("FAIL stuck_and_result got err=%0d fv=%b pass=%b want err=1 fv=000001 pass=0", err0, fv0, pass0);
      end
      and0_stuck = 1'b0;
      tick();
   endtask

   task automatic test_multi_pass();
      int n;
      flt3 = 6'b001000;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      wait_done(3, 200, n);
      checks++;
      if (n !== 36) begin
         errors++;
         $display("FAIL multi_pass_latency got %0d cycles want 36", n);
      end
      checks++;
      if (err3 !== 8'd12 || fv3 !== 6'b001000 || pass3 !== 1'b0) begin
         errors++;
         $display("FAIL multi_pass_result got err=%0d fv=%b pass=%b want err=12 fv=001000 pass=0", err3, fv3, pass3);
      end
      flt3 = 6'd0;
      tick();
   endtask

   task automatic test_saturate();
      int n;
      flt70 = 6'b111111;
      start70 = 1'b1;
      tick();
      start70 = 1'b0;
      wait_done(70, 1000, n);
      checks++;
      if (n !== 560) begin
         errors++;
         $display("FAIL saturate_latency got %0d cycles want 560", n);
      end
      checks++;
      if (err70 !== 8'd255 || fv70 !== 6'b111111 || pass70 !== 1'b0) begin
         errors++;
         $display("FAIL saturate_result got err=%0d fv=%b pass=%b want err=255 fv=111111 pass=0", err70, fv70, pass70);
      end
      flt70 = 6'd0;
      tick();
   endtask

   task automatic test_reset_midrun();
      int n;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick(); tick(); tick(); tick();
      checks++;
      if ({a0, b0} !== 2'b01 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre_reset got ab=%b%b busy=%b want ab=01 busy=1", a0, b0, busy0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0, fv0} !== 19'd0) begin
         errors++;
         $display("FAIL midrun_async_clear got a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b want all 0",
                  a0, b0, busy0, done0, pass0, err0, fv0);
      end
      tick();
      tick();
      rst = 1'b0;
      n = 0;
      for (int k = 0; k < 15; k++) begin
         if (done0 === 1'b1) n++;
         tick();
      end
      checks++;
      if (n !== 0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_done got done_pulses=%0d busy=%b want 0 and 0", n, busy0);
      end
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 100, n);
      checks++;
      if (n !== 12 || pass0 !== 1'b1 || err0 !== 8'd0) begin
         errors++;
         $display("FAIL post_reset_sweep got cycles=%0d pass=%b err=%0d want 12 1 0", n, pass0, err0);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick(); tick(); tick(); tick();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 100, n);
      checks++;
      if (n !== 7) begin
         errors++;
         $display("FAIL ignore_start_latency got %0d remaining cycles want 7", n);
      end
      tick();
      tick();
      start0 = 1'b1;
      tick();
      wait_done(0, 100, n);
      checks++;
      if (n !== 12) begin
         errors++;
         $display("FAIL held_start_first_run got %0d cycles want 12", n);
      end
      tick();
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL held_start_idle_cycle got busy=%b done=%b want 0 0", busy0, done0);
      end
      tick();
      checks++;
      if (busy0 !== 1'b1 || {a0, b0} !== 2'b00) begin
         errors++;
         $display("FAIL held_start_restart got busy=%b ab=%b%b want busy=1 ab=00", busy0, a0, b0);
      end
      start0 = 1'b0;
      wait_done(0, 100, n);
      checks++;
      if (n !== 12 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL held_start_second_run got cycles=%0d pass=%b want 12 1", n, pass0);
      end
      tick();
      tick();
   endtask

`ifdef GATE_SELFTEST_FAULT_INJECT_EN
   task automatic test_inject();
      int n;
      inj0 = 6'b100000;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(0, 100, n);
      checks++;
      if (n !== 12 || err0 !== 8'd4 || fv0 !== 6'b100000 || pass0 !== 1'b0) begin
         errors++;
         $display("FAIL inject_nand got cycles=%0d err=%0d fv=%b pass=%b want 12 4 100000 0", n, err0, fv0, pass0);
      end
      inj0 = 6'd0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_good_sweep();
      test_stuck_and();
      test_multi_pass();
      test_saturate();
      test_reset_midrun();
      test_back_to_back();
`ifdef GATE_SELFTEST_FAULT_INJECT_EN
      test_inject();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
